// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the 6502 core bus: a small TX FIFO
// feeds a START/DATA/STOP serialiser whose bit period is DIV+1 clocks.
module bus_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hF000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd103
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        txd
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic          txd_q, txd_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]   div_q, div_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic wr_en, push_req, push_ok, pop, fifo_empty, fifo_full, bit_done, busy;

    assign sel        = (addr[15:2] == BASE_ADDR[15:2]);
    assign wr_en      = sel && !rw;
    assign push_req   = wr_en && (addr[1:0] == 2'd0);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // A pop on the same edge frees the slot the push lands in.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign bit_done   = (bit_cnt_q == 16'd0);
    assign busy       = (state_q != IDLE);
    assign txd        = txd_q;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        rdata = 8'h00;
        if (sel) begin
            case (addr[1:0])
                2'd0:    rdata = 8'(count_q);
                2'd1:    rdata = {4'b0000, ovf_q, fifo_empty, fifo_full, busy};
                2'd2:    rdata = div_q[7:0];
                default: rdata = div_q[15:8];
            endcase
        end
    end

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_en && addr[1:0] == 2'd1) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop) ovf_d = 1'b1;
        if (wr_en && addr[1:0] == 2'd2) div_d[7:0]  = wdata;
        if (wr_en && addr[1:0] == 2'd3) div_d[15:8] = wdata;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_done ? div_q : bit_cnt_q - 16'd1;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d     = 1'b1;
                bit_cnt_d = div_q;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: FIFO storage is not reset; count and pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= wdata;
    end

    // NOTE: state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            txd_q     <= 1'b1;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            bit_cnt_q <= 16'd0;
            div_q     <= DIV_RESET;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register vector table plus hand-built
// txd waveforms for single, back-to-back, divisor-change and reset cases.
module tb_bus_uart_tx;
    localparam logic [15:0] BASE      = 16'hF000;
    localparam logic [15:0] IDLE_ADDR = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;
    logic        txd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(4),
        .DIV_RESET (16'd103)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .rw   (rw),
        .wdata(wdata),
        .rdata(rdata),
        .sel  (sel),
        .txd  (txd)
    );

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        exp_sel;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        addr  = IDLE_ADDR;
        rw    = 1'b1;
        wdata = 8'h00;
    endtask

    task automatic write_reg(input logic [1:0] off, input logic [7:0] d);
        @(negedge clk);
        addr  = {BASE[15:2], off};
        rw    = 1'b0;
        wdata = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic read_check(input string name, input logic [1:0] off, input logic [7:0] exp);
        addr = {BASE[15:2], off};
        rw   = 1'b1;
        #1;
        check(name, 16'(rdata), 16'(exp));
    endtask

    task automatic push_bits(input logic v, input int len);
        for (int k = 0; k < len; k++) exp_q.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] b, input int len);
        push_bits(1'b0, len);
        for (int i = 0; i < 8; i++) push_bits(b[i], len);
        push_bits(1'b1, len);
    endtask

    task automatic check_txd(input string name);
        logic e;
        e = exp_q.pop_front();
        check(name, 16'(txd), 16'(e));
    endtask

    // One frame from an idle, empty transmitter at the given divisor.
    task automatic run_frame(input logic [7:0] b, input logic [7:0] div);
        int len;
        len = 10 * (int'(div) + 1);
        write_reg(2'd2, div);
        exp_q.delete();
        push_frame(b, int'(div) + 1);
        write_reg(2'd0, b);
        check($sformatf("txd_idle_before_pop_%02h", b), 16'(txd), 16'h0001);
        read_check($sformatf("count_after_write_%02h", b), 2'd0, 8'h01);
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (j == 0) read_check($sformatf("busy_rise_%02h", b), 2'd1, 8'h05);
            check_txd($sformatf("frame_%02h_s%0d", b, j));
        end
        @(negedge clk);
        read_check($sformatf("status_after_frame_%02h", b), 2'd1, 8'h04);
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] burst[6];
        int bad;

        reset = 1'b1;
        idle_bus();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("txd_after_reset", 16'(txd), 16'h0001);

        vecs.push_back('{"rd_count_reset",  16'hF000, 1'b1, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{"rd_status_reset", 16'hF001, 1'b1, 8'h00, 1'b1, 8'h04});
        vecs.push_back('{"rd_divlo_reset",  16'hF002, 1'b1, 8'h00, 1'b1, 8'h67});
        vecs.push_back('{"rd_divhi_reset",  16'hF003, 1'b1, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{"rd_above_window", 16'hF004, 1'b1, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{"rd_below_window", 16'hEFFF, 1'b1, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{"wr_outside",      16'hF004, 1'b0, 8'h55, 1'b0, 8'h00});
        vecs.push_back('{"rd_count_after_outside", 16'hF000, 1'b1, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{"rd_divlo_after_outside", 16'hF002, 1'b1, 8'h00, 1'b1, 8'h67});
        vecs.push_back('{"wr_divlo",        16'hF002, 1'b0, 8'h03, 1'b1, 8'h67});
        vecs.push_back('{"rd_divlo",        16'hF002, 1'b1, 8'h00, 1'b1, 8'h03});
        vecs.push_back('{"wr_divhi",        16'hF003, 1'b0, 8'hAB, 1'b1, 8'h00});
        vecs.push_back('{"rd_divhi",        16'hF003, 1'b1, 8'h00, 1'b1, 8'hAB});
        vecs.push_back('{"wr_divhi_zero",   16'hF003, 1'b0, 8'h00, 1'b1, 8'hAB});
        vecs.push_back('{"rd_divhi_zero",   16'hF003, 1'b1, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{"rd_status_after_div", 16'hF001, 1'b1, 8'h00, 1'b1, 8'h04});

        foreach (vecs[i]) begin
            @(negedge clk);
            addr  = vecs[i].addr;
            rw    = vecs[i].rw;
            wdata = vecs[i].wdata;
            #1;
            check({vecs[i].name, "_sel"}, 16'(sel), 16'(vecs[i].exp_sel));
            check({vecs[i].name, "_rdata"}, 16'(rdata), 16'(vecs[i].exp_rdata));
        end
        @(negedge clk);
        idle_bus();

        run_frame(8'hA5, 8'd3);
        run_frame(8'h96, 8'd0);

        // Six writes on consecutive cycles: five frames back-to-back, sixth dropped.
        write_reg(2'd2, 8'd3);
        burst = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_frame(burst[i], 4);
        for (int t = 0; t < 202; t++) begin
            @(negedge clk);
            if (t < 6) begin
                addr  = BASE;
                rw    = 1'b0;
                wdata = burst[t];
            end else if (t == 6) begin
                idle_bus();
                read_check("burst_status_overflow", 2'd1, 8'h0B);
                read_check("burst_count_full", 2'd0, 8'h04);
            end
            if (t >= 2) check_txd($sformatf("burst_s%0d", t - 2));
        end
        @(negedge clk);
        read_check("burst_end_status", 2'd1, 8'h0C);
        read_check("burst_end_count", 2'd0, 8'h00);
        idle_bus();
        write_reg(2'd1, 8'hFF);
        read_check("overflow_cleared", 2'd1, 8'h04);
        idle_bus();

        // DIV_LO=1 written during data bit 3 of a DIV=3 frame of 0x3C.
        exp_q.delete();
        push_bits(1'b0, 4);
        for (int i = 0; i < 4; i++) push_bits(i >= 2, 4);
        for (int i = 4; i < 8; i++) push_bits(i <= 5, 2);
        push_bits(1'b1, 2);
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (t == 0) begin
                addr  = BASE;
                rw    = 1'b0;
                wdata = 8'h3C;
            end else if (t == 1 || t == 20) begin
                idle_bus();
            end else if (t == 19) begin
                addr  = BASE + 16'd2;
                rw    = 1'b0;
                wdata = 8'h01;
            end
            if (t >= 2) check_txd($sformatf("divchg_s%0d", t - 2));
        end
        @(negedge clk);
        read_check("divchg_status_end", 2'd1, 8'h04);
        read_check("divchg_divlo", 2'd0 + 2'd2, 8'h01);
        idle_bus();

        // Reset mid-DATA with three bytes still queued.
        write_reg(2'd2, 8'd3);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t < 4) begin
                addr  = BASE;
                rw    = 1'b0;
                wdata = 8'h00;
            end else begin
                idle_bus();
            end
        end
        repeat (15) @(negedge clk);
        read_check("pre_reset_count", 2'd0, 8'h03);
        read_check("pre_reset_status", 2'd1, 8'h01);
        check("pre_reset_txd_in_data", 16'(txd), 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("txd_after_midframe_reset", 16'(txd), 16'h0001);
        read_check("count_after_midframe_reset", 2'd0, 8'h00);
        read_check("divlo_after_midframe_reset", 2'd2, 8'h67);
        read_check("divhi_after_midframe_reset", 2'd3, 8'h00);
        read_check("status_after_midframe_reset", 2'd1, 8'h04);
        idle_bus();
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("no_start_bit_after_reset", 16'(bad), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
